// File: rtl/uart_rx_oversampled.sv
`timescale 1ns/1ps
// uart_rx_oversampled
//   8N1 UART receiver that builds its own OVERSAMPLE x baud tick from clk.
//   Each bit is sampled at its middle. Received bytes go out with a single-clk valid strobe.
//   Optional feature macro: UART_RX_PARITY_EN. It adds an even-parity bit after the data
//   bits and a parity_err output.
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       asynchronous active-low reset (released synchronously inside)
//   rx          serial line, idle high, asynchronous to clk
//   data_out    last received byte (held until the next frame completes)
//   data_valid  one-clk pulse, good new byte on data_out
//   frame_err   one-clk pulse, stop bit sampled low
//   busy        high from start-bit detect until return to IDLE
//   parity_err  (UART_RX_PARITY_EN only) one-clk pulse alongside data_valid
module uart_rx_oversampled #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    // Reset synchroniser. Assertion is immediate. Release waits two clocks so that
    // every flop leaves reset on the same edge.
    logic r_rst_meta, r_rst_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {r_rst_sync, r_rst_meta} <= 2'b00;
        else        {r_rst_sync, r_rst_meta} <= {r_rst_meta, 1'b1};
    end

    logic w_rst_n;
    assign w_rst_n = r_rst_sync;

    // Two-flop synchroniser on rx. It resets to idle-high so reset is not taken as a start bit.
    logic [1:0] r_sync;
    logic       w_rx;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], rx};
    end
    assign w_rx = r_sync[1];

    // Free-running oversample divider. Its phase relative to a start edge is arbitrary,
    // so the mid-bit sample point can be up to one tick late.
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;
    assign w_tick = (r_div_cnt == DIV_LAST);
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)    r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    logic [2:0]      r_state;
    logic [OS_W-1:0] r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_data_out;
    logic            r_valid, r_ferr, r_busy;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bit, r_perr;
`endif

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                // IDLE is checked every clk, so a new start edge is caught right after STOP.
                S_IDLE: if (!w_rx) begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_busy     <= 1'b1;
                    r_state    <= S_START;
                end
                // Confirm the start bit at its middle. From then on every OVERSAMPLE
                // ticks lands mid-bit.
                S_START: if (w_tick) begin
                    if (r_tick_cnt == OS_HALF) begin
                        r_tick_cnt <= '0;
                        if (w_rx) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_DATA: if (w_tick) begin
                    if (r_tick_cnt == OS_LAST) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {w_rx, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (w_tick) begin
                    if (r_tick_cnt == OS_LAST) begin
                        r_tick_cnt <= '0;
                        r_par_bit  <= w_rx;
                        r_state    <= S_STOP;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: if (w_tick) begin
                    if (r_tick_cnt == OS_LAST) begin
                        r_tick_cnt <= '0;
                        r_data_out <= r_shift;
                        if (w_rx) begin
                            r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= ^{r_shift, r_par_bit};
`endif
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            // A low stop bit is either a framing error or a break.
                            // Hold off until the line recovers.
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                    end
                end
                S_BREAK: if (w_rx) begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_oversampled. The baud rate is raised so that one bit is
// 160 clk, which keeps runtime short. Timing bounds are scaled from the nominal
// 5200-clk bit to match.
module tb_uart_rx_oversampled;
    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 625_000;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int LAT      = BIT * 21 / 2;
`else
    localparam int LAT      = BIT * 19 / 2;
`endif
    localparam int LAT_TOL  = DIV + 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, frame_err, busy;
    logic       w_perr;
`ifdef UART_RX_PARITY_EN
    bit         par_flip = 1'b0;
`else
    assign w_perr = 1'b0;
`endif

    uart_rx_oversampled #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (w_perr),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] vq[$];
    int         vt[$];
    logic       pq[$];
    logic [7:0] fq[$];
    int         both = 0;
    always @(negedge clk) begin
        if (data_valid) begin
            vq.push_back(data_out);
            vt.push_back(cyc);
            pq.push_back(w_perr);
        end
        if (frame_err) fq.push_back(data_out);
        if (data_valid && frame_err) both++;
    end

    task automatic clear_mon();
        vq.delete(); vt.delete(); pq.delete(); fq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered and left at a negedge, so frames sent back to back have no gap.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_len,
                              output logic busy_mid, output int t_start);
        rx = 1'b0;
        t_start = cyc;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT);
            if (i == 1) busy_mid = busy;
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        idle(BIT);
`endif
        rx = stop_val;
        idle(stop_len);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0; rx = 1'b1;
        idle(10);
        checks++;
        if ({data_out, data_valid, frame_err, busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_held: outs=%h required 0", {data_out, data_valid, frame_err, busy});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4 * BIT; i++) begin
            @(negedge clk);
            if (data_valid || frame_err || busy || data_out != 8'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_idle: %0d cycles with nonzero outputs, required 0", bad);
        end
        checks++;
        if (vq.size() + fq.size() !== 0) begin
            failures++;
            $display("FAIL reset_pulses: got %0d pulses, required 0", vq.size() + fq.size());
        end
    endtask

    task automatic test_single();
        logic bm; int t0; int lat;
        clear_mon();
        send_frame(8'hA5, 1'b1, BIT, bm, t0);
        idle(BIT);
        checks++;
        if (vq.size() !== 1) begin
            failures++;
            $display("FAIL single_count: got %0d pulses, required 1", vq.size());
        end else begin
            checks++;
            if (vq[0] !== 8'hA5) begin
                failures++;
                $display("FAIL single_data: got %h required a5", vq[0]);
            end
            lat = vt[0] - t0;
            checks++;
            if (lat < LAT - LAT_TOL || lat > LAT + LAT_TOL) begin
                failures++;
                $display("FAIL single_latency: got %0d clk, required %0d +/- %0d", lat, LAT, LAT_TOL);
            end
        end
        checks++;
        if (fq.size() !== 0) begin
            failures++;
            $display("FAIL single_ferr: got %0d frame_err pulses, required 0", fq.size());
        end
        checks++;
        if (data_out !== 8'hA5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: data_out=%h busy=%b required a5/0", data_out, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        logic       bm  [3];
        int t0;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, BIT, bm[i], t0);
        idle(2 * BIT);
        checks++;
        if (vq.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count: got %0d pulses, required 3", vq.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (vq[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL b2b_data%0d: got %h required %h", i, vq[i], exp[i]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bm[i] !== 1'b1) begin
                failures++;
                $display("FAIL b2b_busy%0d: busy mid-frame %b required 1", i, bm[i]);
            end
        end
        checks++;
        if (fq.size() !== 0) begin
            failures++;
            $display("FAIL b2b_ferr: got %0d frame_err pulses, required 0", fq.size());
        end
    endtask

    task automatic test_glitch();
        logic seen; int waited = 0;
        clear_mon();
        rx = 1'b0;
        idle(30);
        seen = busy;
        rx = 1'b1;
        while (busy && waited < BIT / 2 + DIV + 10) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_set: busy=%b during low pulse, required 1", seen);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_clear: busy=%b after %0d clk, required 0", busy, waited);
        end
        idle(11 * BIT);
        checks++;
        if (vq.size() + fq.size() !== 0) begin
            failures++;
            $display("FAIL glitch_pulses: got %0d pulses, required 0", vq.size() + fq.size());
        end
    endtask

    task automatic test_framing();
        logic bm; int t0;
        clear_mon();
        send_frame(8'h3C, 1'b0, 4 * BIT, bm, t0);
        idle(BIT);
        checks++;
        if (fq.size() !== 1 || vq.size() !== 0) begin
            failures++;
            $display("FAIL ferr_pulses: frame_err=%0d valid=%0d, required 1/0", fq.size(), vq.size());
        end else begin
            checks++;
            if (fq[0] !== 8'h3C) begin
                failures++;
                $display("FAIL ferr_data: got %h required 3c", fq[0]);
            end
        end
        send_frame(8'h81, 1'b1, BIT, bm, t0);
        idle(BIT);
        checks++;
        if (vq.size() !== 1 || fq.size() !== 1) begin
            failures++;
            $display("FAIL ferr_recover: valid=%0d frame_err=%0d, required 1/1", vq.size(), fq.size());
        end else begin
            checks++;
            if (vq[0] !== 8'h81) begin
                failures++;
                $display("FAIL ferr_next_data: got %h required 81", vq[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bm; int t0;
        clear_mon();
        rx = 1'b0;
        idle(3 * BIT);
        rst_n = 1'b0;
        idle(5);
        checks++;
        if (busy !== 1'b0 || data_out !== 8'd0) begin
            failures++;
            $display("FAIL midrst_outs: busy=%b data_out=%h required 0/00", busy, data_out);
        end
        rx = 1'b1;
        rst_n = 1'b1;
        idle(12 * BIT);
        checks++;
        if (vq.size() + fq.size() !== 0) begin
            failures++;
            $display("FAIL midrst_pulses: got %0d pulses, required 0", vq.size() + fq.size());
        end
        send_frame(8'h42, 1'b1, BIT, bm, t0);
        idle(BIT);
        checks++;
        if (vq.size() !== 1) begin
            failures++;
            $display("FAIL midrst_fresh_count: got %0d pulses, required 1", vq.size());
        end else begin
            checks++;
            if (vq[0] !== 8'h42) begin
                failures++;
                $display("FAIL midrst_fresh_data: got %h required 42", vq[0]);
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic bm; int t0;
        clear_mon();
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, BIT, bm, t0);
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, BIT, bm, t0);
        par_flip = 1'b0;
        idle(BIT);
        checks++;
        if (vq.size() !== 2 || fq.size() !== 0) begin
            failures++;
            $display("FAIL parity_count: valid=%0d frame_err=%0d required 2/0", vq.size(), fq.size());
        end else begin
            checks++;
            if (vq[0] !== 8'h07 || vq[1] !== 8'h07) begin
                failures++;
                $display("FAIL parity_data: got %h %h required 07 07", vq[0], vq[1]);
            end
            checks++;
            if (pq[0] !== 1'b0 || pq[1] !== 1'b1) begin
                failures++;
                $display("FAIL parity_err: got %b %b required 0 1", pq[0], pq[1]);
            end
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (both !== 0) begin
            failures++;
            $display("FAIL exclusive: valid and frame_err together %0d times, required 0", both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
